// File: rtl/lp805x_clkctrl.sv
`default_nettype none
// ============================================================================
// Module      : lp805x_clkctrl
// Description : SFR-mapped clock-source controller for the lp805x core.
//               Sequences the secondary oscillator (enable, startup wait)
//               and drives the glitch-free clock switch select line, holding
//               it through a settle window before accepting a new request.
//               Optional switch-done interrupt flag: LP805X_CLKCTRL_INT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lp805x_clkctrl #(
    parameter logic [7:0] SFR_ADDR       = 8'hC7,
    parameter int         STARTUP_CYCLES = 1024,
    parameter int         SETTLE_CYCLES  = 8,
    parameter int         CNT_W          = 11
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       wr,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_dat,
    input  logic [7:0] rd_addr,
    output logic [7:0] dat_o,
    output logic       sfr_hit_o,
    output logic       osc2_en_o,
    output logic       select_o,
    output logic       busy_o,
    output logic       int_o
);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_wait_rdy = 2'd1;
    localparam logic [1:0] c_st_settle   = 2'd2;

    localparam logic [CNT_W-1:0] c_startup_last = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_settle_last  = CNT_W'(SETTLE_CYCLES - 1);

    logic [1:0]       r_state;
    logic             r_sel_req;
    logic             r_osc2_keep;
    logic             r_osc2_rdy;
    logic             r_osc2_en;
    logic             r_select;
    logic [CNT_W-1:0] r_startup_cnt;
    logic [CNT_W-1:0] r_settle_cnt;
    logic             w_wr_hit;
    logic             w_settle_exit;
    logic             w_done_if;
    logic             w_unused_wr;

    assign w_wr_hit      = wr && (wr_addr == SFR_ADDR);
    assign w_settle_exit = (r_state == c_st_settle) && (r_settle_cnt == c_settle_last);
    // Bits 2..6 of the write data carry no storage.
    assign w_unused_wr   = &{1'b0, wr_dat[7:2]};

    // Software-writable control bits.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sel_req   <= 1'b0;
            r_osc2_keep <= 1'b0;
        end else if (w_wr_hit) begin
            r_sel_req   <= wr_dat[0];
            r_osc2_keep <= wr_dat[1];
        end
    end

    // Oscillator enable and startup timer; ready stays up while enabled.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_osc2_en     <= 1'b0;
            r_osc2_rdy    <= 1'b0;
            r_startup_cnt <= '0;
        end else begin
            r_osc2_en <= r_osc2_keep | r_sel_req | r_select | (r_state != c_st_idle);
            if (!r_osc2_en) begin
                r_osc2_rdy    <= 1'b0;
                r_startup_cnt <= '0;
            end else if (!r_osc2_rdy) begin
                if (r_startup_cnt == c_startup_last) begin
                    r_osc2_rdy <= 1'b1;
                end else begin
                    r_startup_cnt <= r_startup_cnt + 1'b1;
                end
            end
        end
    end

    // Switch sequencer: request, wait for oscillator, then hold select through settle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= c_st_idle;
            r_select     <= 1'b0;
            r_settle_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (r_sel_req && !r_select) begin
                        r_state <= c_st_wait_rdy;
                    end else if (!r_sel_req && r_select) begin
                        r_select     <= 1'b0;
                        r_settle_cnt <= '0;
                        r_state      <= c_st_settle;
                    end
                end
                c_st_wait_rdy: begin
                    // An abort wins over a coincident ready so select never rises.
                    if (!r_sel_req) begin
                        r_state <= c_st_idle;
                    end else if (r_osc2_rdy) begin
                        r_select     <= 1'b1;
                        r_settle_cnt <= '0;
                        r_state      <= c_st_settle;
                    end
                end
                c_st_settle: begin
                    if (w_settle_exit) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

`ifdef LP805X_CLKCTRL_INT_EN
    logic r_done_if;

    // Done flag: hardware set beats a simultaneous software clear.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_done_if <= 1'b0;
        end else if (w_settle_exit) begin
            r_done_if <= 1'b1;
        end else if (w_wr_hit && !wr_dat[7]) begin
            r_done_if <= 1'b0;
        end
    end

    assign w_done_if = r_done_if;
`else
    assign w_done_if = 1'b0;
`endif

    assign osc2_en_o = r_osc2_en;
    assign select_o  = r_select;
    assign busy_o    = (r_state != c_st_idle);
    assign int_o     = w_done_if;
    assign sfr_hit_o = (rd_addr == SFR_ADDR);
    assign dat_o     = sfr_hit_o ? {w_done_if, busy_o, r_osc2_rdy, r_select,
                                    2'b00, r_osc2_keep, r_sel_req}
                                 : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_lp805x_clkctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lp805x_clkctrl
// Description : Directed self-checking bench for lp805x_clkctrl with
//               STARTUP_CYCLES=16, SETTLE_CYCLES=4. Done-flag expectations
//               follow LP805X_CLKCTRL_INT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lp805x_clkctrl;

`ifdef LP805X_CLKCTRL_INT_EN
    localparam logic c_done = 1'b1;
`else
    localparam logic c_done = 1'b0;
`endif

    logic       r_clk = 1'b0;
    logic       r_rst;
    logic       r_wr;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_dat;
    logic [7:0] r_rd_addr;
    logic [7:0] w_dat;
    logic       w_hit;
    logic       w_osc2_en;
    logic       w_select;
    logic       w_busy;
    logic       w_int;

    int n_tests = 0;
    int n_fail  = 0;

    lp805x_clkctrl #(
        .SFR_ADDR       (8'hC7),
        .STARTUP_CYCLES (16),
        .SETTLE_CYCLES  (4),
        .CNT_W          (11)
    ) u_dut (
        .wb_clk_i  (r_clk),
        .wb_rst_i  (r_rst),
        .wr        (r_wr),
        .wr_addr   (r_wr_addr),
        .wr_dat    (r_wr_dat),
        .rd_addr   (r_rd_addr),
        .dat_o     (w_dat),
        .sfr_hit_o (w_hit),
        .osc2_en_o (w_osc2_en),
        .select_o  (w_select),
        .busy_o    (w_busy),
        .int_o     (w_int)
    );

    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%02h, expected 'h%02h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns later.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge r_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        r_rst = 1'b1;
        step(1);
        r_rst = 1'b0;
    endtask

    // Write lands on the next edge (edge 0); returns 1 ns after it.
    task automatic sfr_write(input logic [7:0] addr, input logic [7:0] d);
        r_wr      = 1'b1;
        r_wr_addr = addr;
        r_wr_dat  = d;
        step(1);
        r_wr      = 1'b0;
    endtask

    logic r_seen_sel;
    logic r_seen_rdy;

    initial begin
        r_rst     = 1'b1;
        r_wr      = 1'b0;
        r_wr_addr = 8'h00;
        r_wr_dat  = 8'h00;
        r_rd_addr = 8'hC7;

        // Reset state and address decode.
        do_reset();
        check("rst_dat",     w_dat, 8'h00);
        check("rst_hit",     {7'd0, w_hit}, 8'h01);
        check("rst_select",  {7'd0, w_select}, 8'h00);
        check("rst_osc2_en", {7'd0, w_osc2_en}, 8'h00);
        check("rst_busy",    {7'd0, w_busy}, 8'h00);
        check("rst_int",     {7'd0, w_int}, 8'h00);
        r_rd_addr = 8'h80;
        #1;
        check("miss_dat", w_dat, 8'h00);
        check("miss_hit", {7'd0, w_hit}, 8'h00);
        r_rd_addr = 8'hC7;

        // Writes to another address and to b2/b3 are ignored.
        sfr_write(8'h80, 8'hFF);
        check("other_addr_wr", w_dat, 8'h00);
        sfr_write(8'hC7, 8'h0C);
        check("rsvd_bits_wr", w_dat, 8'h00);

        // Select clk_2: startup wait, select, settle, done.
        sfr_write(8'hC7, 8'h01);
        check("sel_e0_busy", {7'd0, w_busy}, 8'h00);
        step(1);
        check("sel_e1_busy",    {7'd0, w_busy}, 8'h01);
        check("sel_e1_osc2_en", {7'd0, w_osc2_en}, 8'h01);
        check("sel_e1_dat",     w_dat, 8'h41);
        step(15);
        check("sel_e16_dat", w_dat, 8'h41);
        step(1);
        check("sel_e17_dat", w_dat, 8'h61);
        step(1);
        check("sel_e18_select", {7'd0, w_select}, 8'h01);
        step(3);
        check("sel_e21_busy", {7'd0, w_busy}, 8'h01);
        check("sel_e21_int",  {7'd0, w_int}, 8'h00);
        step(1);
        check("sel_e22_busy", {7'd0, w_busy}, 8'h00);
        check("sel_e22_int",  {7'd0, w_int}, {7'd0, c_done});
        check("sel_e22_dat",  w_dat, {c_done, 7'h31});

        // Deselect with OSC2_KEEP: oscillator stays up, reselect skips startup.
        sfr_write(8'hC7, 8'h02);
        step(1);
        check("desel_e1_select", {7'd0, w_select}, 8'h00);
        check("desel_e1_busy",   {7'd0, w_busy}, 8'h01);
        step(3);
        check("desel_e4_busy", {7'd0, w_busy}, 8'h01);
        step(1);
        check("desel_e5_busy",    {7'd0, w_busy}, 8'h00);
        check("desel_e5_osc2_en", {7'd0, w_osc2_en}, 8'h01);
        check("desel_e5_dat",     w_dat, {c_done, 7'h22});
        sfr_write(8'hC7, 8'h03);
        step(1);
        check("resel_e1_select", {7'd0, w_select}, 8'h00);
        step(1);
        check("resel_e2_select", {7'd0, w_select}, 8'h01);
        step(4);
        check("resel_e6_dat", w_dat, {c_done, 7'h33});

        // Abort during startup: select and ready never rise.
        do_reset();
        sfr_write(8'hC7, 8'h01);
        step(4);
        sfr_write(8'hC7, 8'h00);
        step(1);
        check("abort_e6_busy",    {7'd0, w_busy}, 8'h00);
        check("abort_e6_osc2_en", {7'd0, w_osc2_en}, 8'h01);
        step(1);
        check("abort_e7_osc2_en", {7'd0, w_osc2_en}, 8'h00);
        r_seen_sel = 1'b0;
        r_seen_rdy = 1'b0;
        for (int i = 0; i < 24; i++) begin
            r_seen_sel |= w_select;
            r_seen_rdy |= w_dat[5];
            step(1);
        end
        check("abort_never_sel", {7'd0, r_seen_sel}, 8'h00);
        check("abort_never_rdy", {7'd0, r_seen_rdy}, 8'h00);
        check("abort_dat",       w_dat, 8'h00);
        check("abort_int",       {7'd0, w_int}, 8'h00);

        // Done set wins over a coincident write of b7=0.
        do_reset();
        sfr_write(8'hC7, 8'h01);
        step(20);
        check("prio_e20_busy", {7'd0, w_busy}, 8'h01);
        step(1);
        sfr_write(8'hC7, 8'h01);
        check("prio_set_dat", w_dat, {c_done, 7'h31});
        check("prio_set_int", {7'd0, w_int}, {7'd0, c_done});
        sfr_write(8'hC7, 8'h01);
        check("prio_clr_dat", w_dat, 8'h31);
        check("prio_clr_int", {7'd0, w_int}, 8'h00);

        // Reset in the middle of the settle window.
        do_reset();
        sfr_write(8'hC7, 8'h01);
        step(19);
        check("mid_e19_select", {7'd0, w_select}, 8'h01);
        r_rst = 1'b1;
        step(1);
        r_rst = 1'b0;
        check("midrst_select",  {7'd0, w_select}, 8'h00);
        check("midrst_osc2_en", {7'd0, w_osc2_en}, 8'h00);
        check("midrst_busy",    {7'd0, w_busy}, 8'h00);
        check("midrst_int",     {7'd0, w_int}, 8'h00);
        check("midrst_dat",     w_dat, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
